// File: rtl/control_pkg.sv
// control_pkg: opcode, select-code and state definitions shared by the control sequencer
package control_pkg;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd12;
   localparam logic [3:0] ALU_SRA   = 4'd13;
   localparam logic [3:0] ALU_PASSB = 4'd15;
   localparam logic [2:0] IMM_NONE = 3'b000;
   localparam logic [2:0] IMM_I    = 3'b001;
   localparam logic [2:0] IMM_S    = 3'b010;
   localparam logic [2:0] IMM_B    = 3'b011;
   localparam logic [2:0] IMM_U    = 3'b100;
   localparam logic [2:0] IMM_J    = 3'b101;
   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_ALU = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;
   typedef struct packed {
      logic       a_sel;
      logic       b_sel;
      logic       pc_sel;
      logic       store;
      logic [2:0] imm_sel;
      logic [3:0] alu_sel;
      logic [1:0] wb_sel;
   } ctrl_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational RV32I decoder producing the control bundle and legality flags
module control_decode
   import control_pkg::*;
(
   input  logic [31:0] instruction,
   output ctrl_t       ctrl,
   output logic        illegal,
   output logic        is_mem,
   output logic        is_branch,
   output logic        writes_rd
);
   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   assign op = instruction[6:0];
   assign f3 = instruction[14:12];
   assign f7 = instruction[31:25];
   always_comb begin
      ctrl = '0;
      illegal = 1'b0;
      is_mem = 1'b0;
      is_branch = 1'b0;
      writes_rd = 1'b0;
      case (op)
         OP_R: begin
            illegal = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            ctrl.alu_sel = f7[5] ? (f3 == 3'b000 ? ALU_SUB : ALU_SRA) : {1'b0, f3};
            ctrl.wb_sel = WB_ALU;
            writes_rd = 1'b1;
         end
         OP_I: begin
            illegal = (f3 == 3'b001 && f7 != 7'b0000000) ||
                      (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            ctrl.alu_sel = (f3 == 3'b101 && f7[5]) ? ALU_SRA : {1'b0, f3};
            ctrl.b_sel = 1'b1;
            ctrl.imm_sel = IMM_I;
            ctrl.wb_sel = WB_ALU;
            writes_rd = 1'b1;
         end
         OP_LUI: begin
            ctrl.b_sel = 1'b1;
            ctrl.imm_sel = IMM_U;
            ctrl.alu_sel = ALU_PASSB;
            ctrl.wb_sel = WB_ALU;
            writes_rd = 1'b1;
         end
         OP_AUIPC: begin
            ctrl.a_sel = 1'b1;
            ctrl.b_sel = 1'b1;
            ctrl.imm_sel = IMM_U;
            ctrl.alu_sel = ALU_ADD;
            ctrl.wb_sel = WB_ALU;
            writes_rd = 1'b1;
         end
         OP_JAL: begin
            ctrl.a_sel = 1'b1;
            ctrl.b_sel = 1'b1;
            ctrl.imm_sel = IMM_J;
            ctrl.pc_sel = 1'b1;
            ctrl.wb_sel = WB_PC4;
            writes_rd = 1'b1;
         end
         OP_JALR: begin
            ctrl.b_sel = 1'b1;
            ctrl.imm_sel = IMM_I;
            ctrl.pc_sel = 1'b1;
            ctrl.wb_sel = WB_PC4;
            writes_rd = 1'b1;
         end
         OP_BR: begin
            illegal = f3 == 3'b010 || f3 == 3'b011;
            ctrl.a_sel = 1'b1;
            ctrl.b_sel = 1'b1;
            ctrl.imm_sel = IMM_B;
            is_branch = 1'b1;
         end
         OP_LD: begin
            illegal = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
            ctrl.b_sel = 1'b1;
            ctrl.imm_sel = IMM_I;
            ctrl.wb_sel = WB_MEM;
            is_mem = 1'b1;
            writes_rd = 1'b1;
         end
         OP_ST: begin
            illegal = f3 > 3'b010;
            ctrl.b_sel = 1'b1;
            ctrl.imm_sel = IMM_S;
            ctrl.store = 1'b1;
            is_mem = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         ctrl = '0;
         is_mem = 1'b0;
         is_branch = 1'b0;
         writes_rd = 1'b0;
      end
   end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle RV32I control FSM with memory timeout and retired-instruction counter
module control_sequencer
   import control_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 32,
   parameter int ALU_SEL_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instruction,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic                 branch_taken,
   input  logic                 mem_ack,
   output logic                 mem_req,
   output logic                 pc_write,
   output logic                 pc_select,
   output logic                 a_select,
   output logic                 b_select,
   output logic [2:0]           immediate_select,
   output logic [ALU_SEL_W-1:0] alu_select,
   output logic [1:0]           write_back_select,
   output logic                 register_write_enable,
   output logic                 memory_write_enable,
   output logic                 illegal,
   output logic                 mem_fault,
   output logic                 busy,
   output logic [CNT_W-1:0]     instret
);
   localparam int WW = $clog2(MEM_WAIT_MAX + 1);
   state_t      state;
   logic [31:0] instr_q;
   logic [WW-1:0] wait_cnt;
   ctrl_t       dec_ctrl;
   logic        dec_illegal, dec_mem, dec_branch, dec_rd;
   control_decode u_decode (
      .instruction (instr_q),
      .ctrl        (dec_ctrl),
      .illegal     (dec_illegal),
      .is_mem      (dec_mem),
      .is_branch   (dec_branch),
      .writes_rd   (dec_rd)
   );
   assign instr_ready = state == FETCH;
   assign busy = state != FETCH;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         instr_q <= '0;
         wait_cnt <= '0;
         instret <= '0;
         mem_req <= 1'b0;
         pc_write <= 1'b0;
         pc_select <= 1'b0;
         a_select <= 1'b0;
         b_select <= 1'b0;
         immediate_select <= IMM_NONE;
         alu_select <= '0;
         write_back_select <= WB_MEM;
         register_write_enable <= 1'b0;
         memory_write_enable <= 1'b0;
         illegal <= 1'b0;
         mem_fault <= 1'b0;
      end else begin
         case (state)
            FETCH: if (instr_valid) begin
               instr_q <= instruction;
               state <= DECODE;
            end
            DECODE: begin
               a_select <= dec_ctrl.a_sel;
               b_select <= dec_ctrl.b_sel;
               pc_select <= dec_ctrl.pc_sel;
               immediate_select <= dec_ctrl.imm_sel;
               alu_select <= ALU_SEL_W'(dec_ctrl.alu_sel);
               write_back_select <= dec_ctrl.wb_sel;
               illegal <= dec_illegal;
               state <= dec_illegal ? WRITEBACK : EXECUTE;
            end
            EXECUTE: begin
               if (dec_branch) pc_select <= branch_taken;
               wait_cnt <= '0;
               if (dec_mem) begin
                  mem_req <= 1'b1;
                  memory_write_enable <= dec_ctrl.store;
                  state <= MEMORY;
               end else begin
                  pc_write <= 1'b1;
                  register_write_enable <= dec_rd;
                  state <= WRITEBACK;
               end
            end
            MEMORY: begin
               wait_cnt <= wait_cnt + 1'b1;
               // an ack arriving on the timeout cycle still completes normally
               if (mem_ack || wait_cnt == WW'(MEM_WAIT_MAX - 1)) begin
                  mem_req <= 1'b0;
                  memory_write_enable <= 1'b0;
                  pc_write <= 1'b1;
                  register_write_enable <= mem_ack && dec_rd;
                  mem_fault <= !mem_ack;
                  wait_cnt <= '0;
                  state <= WRITEBACK;
               end
            end
            WRITEBACK: begin
               if (register_write_enable) instret <= instret + 1'b1;
               pc_write <= 1'b0;
               register_write_enable <= 1'b0;
               illegal <= 1'b0;
               mem_fault <= 1'b0;
               state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized self-checking bench against a behavioural instruction model
module tb_control_sequencer;
   localparam int MW = 4;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] instruction = '0;
   logic        instr_valid = 1'b0, branch_taken = 1'b0, mem_ack = 1'b0;
   logic        instr_ready, mem_req, pc_write, pc_select, a_select, b_select;
   logic [2:0]  immediate_select;
   logic [3:0]  alu_select;
   logic [1:0]  write_back_select;
   logic        register_write_enable, memory_write_enable, illegal, mem_fault, busy;
   logic [31:0] instret;
   int          total = 0, bad = 0, retired = 0;
   logic [31:0] cur_w = '0;
   logic [6:0]  ops [0:8] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};

   always #5 clk = ~clk;

   control_sequencer #(.MEM_WAIT_MAX(MW), .CNT_W(32), .ALU_SEL_W(4)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .branch_taken(branch_taken), .mem_ack(mem_ack),
      .mem_req(mem_req), .pc_write(pc_write), .pc_select(pc_select), .a_select(a_select),
      .b_select(b_select), .immediate_select(immediate_select), .alu_select(alu_select),
      .write_back_select(write_back_select), .register_write_enable(register_write_enable),
      .memory_write_enable(memory_write_enable), .illegal(illegal), .mem_fault(mem_fault),
      .busy(busy), .instret(instret)
   );

   typedef struct packed {
      logic       legal, mem, st, rd, a, b, jmp, brn;
      logic [2:0] imm;
      logic [3:0] alu;
      logic [1:0] wb;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s instr=%h got=%0h want=%0h", tag, cur_w, got, want);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      logic [2:0] f3;
      logic [6:0] f7;
      e = '0;
      f3 = w[14:12];
      f7 = w[31:25];
      e.legal = 1'b1;
      case (w[6:0])
         7'h33: begin
            e.rd = 1; e.wb = 1;
            e.legal = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            e.alu = f7 == 0 ? {1'b0, f3} : (f3 == 0 ? 4'd12 : 4'd13);
         end
         7'h13: begin
            e.rd = 1; e.wb = 1; e.b = 1; e.imm = 1;
            e.legal = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20);
            e.alu = (f3 == 5 && f7 == 7'h20) ? 4'd13 : {1'b0, f3};
         end
         7'h37: begin e.rd = 1; e.wb = 1; e.b = 1; e.imm = 4; e.alu = 15; end
         7'h17: begin e.rd = 1; e.wb = 1; e.a = 1; e.b = 1; e.imm = 4; end
         7'h6f: begin e.rd = 1; e.wb = 2; e.a = 1; e.b = 1; e.imm = 5; e.jmp = 1; end
         7'h67: begin e.rd = 1; e.wb = 2; e.b = 1; e.imm = 1; e.jmp = 1; end
         7'h63: begin e.brn = 1; e.a = 1; e.b = 1; e.imm = 3; e.legal = f3 != 2 && f3 != 3; end
         7'h03: begin e.mem = 1; e.rd = 1; e.b = 1; e.imm = 1; e.legal = f3 inside {0, 1, 2, 4, 5}; end
         7'h23: begin e.mem = 1; e.st = 1; e.b = 1; e.imm = 2; e.legal = f3 <= 2; end
         default: e.legal = 1'b0;
      endcase
      return e;
   endfunction

   // ack_at: MEMORY cycle (1-based) in which mem_ack is raised; 0 or >MW means never
   task automatic run(input logic [31:0] w, input logic taken, input int ack_at);
      exp_t e;
      int n, wb_at, reqs, wes, pcw, rwe, ill, flt, exp_wb, exp_reqs;
      logic fault;
      e = model(w);
      cur_w = w;
      n = 0; wb_at = 0; reqs = 0; wes = 0; pcw = 0; rwe = 0; ill = 0; flt = 0;
      for (int i = 0; i < 20 && !instr_ready; i++) begin @(posedge clk); #1; end
      chk("ready", instr_ready, 1);
      instruction = w;
      instr_valid = 1'b1;
      branch_taken = taken;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instruction = $urandom;
      n = 1;
      while (busy && n < 40) begin
         wb_at = n;
         reqs += mem_req;
         wes += memory_write_enable;
         pcw += pc_write;
         rwe += register_write_enable;
         ill += illegal;
         flt += mem_fault;
         if (pc_write || illegal) begin
            if (e.legal) begin
               chk("alu", alu_select, e.alu);
               chk("imm", immediate_select, e.imm);
               chk("a_sel", a_select, e.a);
               chk("b_sel", b_select, e.b);
               chk("wb_sel", write_back_select, e.wb);
               chk("pc_sel", pc_select, e.jmp | (e.brn & taken));
            end
         end
         mem_ack = mem_req ? (reqs == ack_at) : 1'($urandom_range(0, 1));
         instr_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      mem_ack = 1'b0;
      instr_valid = 1'b0;
      fault = e.legal && e.mem && !(ack_at >= 1 && ack_at <= MW);
      exp_reqs = (e.legal && e.mem) ? (fault ? MW : ack_at) : 0;
      exp_wb = !e.legal ? 2 : !e.mem ? 3 : 3 + exp_reqs;
      chk("idle", busy, 0);
      chk("wb_cycle", wb_at, exp_wb);
      chk("req_cycles", reqs, exp_reqs);
      chk("mwe_cycles", wes, e.st ? exp_reqs : 0);
      chk("pc_write", pcw, e.legal ? 1 : 0);
      chk("reg_we", rwe, (e.legal && e.rd && !fault) ? 1 : 0);
      chk("illegal", ill, e.legal ? 0 : 1);
      chk("mem_fault", flt, fault ? 1 : 0);
      if (e.legal && e.rd && !fault) retired++;
      chk("instret", instret, retired);
      chk("fetch_strobes", {pc_write, register_write_enable, mem_req, memory_write_enable, illegal, mem_fault}, 0);
   endtask

   function automatic logic [31:0] gen();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) w[6:0] = ops[k];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
      return w;
   endfunction

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ready", instr_ready, 1);
      chk("rst_outputs", {pc_write, pc_select, a_select, b_select, immediate_select, alu_select,
                          write_back_select, register_write_enable, memory_write_enable,
                          illegal, mem_fault, mem_req, busy}, 0);
      chk("rst_instret", instret, 0);
      @(posedge clk); #1;
      run(32'h002081B3, 1'b0, 0);
      run(32'h402081B3, 1'b0, 0);
      run(32'h4040D093, 1'b0, 0);
      run(32'h0020A223, 1'b0, 3);
      run(32'h00208463, 1'b1, 0);
      run(32'h00208463, 1'b0, 0);
      run(32'h0000A183, 1'b0, 0);
      run(32'h0000A183, 1'b0, MW);
      run(32'h0000A183, 1'b0, 1);
      run(32'h00000000, 1'b0, 0);
      run(32'h0000A183, 1'b0, 2);
      for (int i = 0; i < 300; i++)
         run(gen(), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
      cur_w = 32'h0000A183;
      instruction = cur_w;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      for (int i = 0; i < 10 && !mem_req; i++) begin @(posedge clk); #1; end
      chk("mid_mem_req", mem_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      retired = 0;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_ready_mid", instr_ready, 1);
      chk("rst_instret_mid", instret, 0);
      chk("rst_writes", {register_write_enable, memory_write_enable, pc_write}, 0);
      run(32'h002081B3, 1'b0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit for the RV32I core. It accepts one instruction at a time over a valid/ready fetch handshake, decodes it, and steps through DECODE, EXECUTE, an optional MEMORY phase and WRITEBACK. It drives the datapath select lines, write strobes, the PC update and the memory request handshake. It also adds what a purely combinational decoder lacks: B-type branches, illegal-instruction detection, a memory timeout and an instructions-retired counter.

## Interface
- MEM_WAIT_MAX, 15: max MEMORY cycles without mem_ack before fault (≥1)
- CNT_W, 32: instret counter width
- ALU_SEL_W, 4: alu_select width (≥4)
- clk input 1: clock
- rst input 1: synchronous, active-high reset
- instruction input 32: instruction word, sampled on fetch handshake
- instr_valid input 1: fetch offers instruction
- instr_ready output 1: high only in FETCH
- branch_taken input 1: comparator result, sampled in EXECUTE
- mem_ack input 1: memory completes access
- mem_req output 1: held through MEMORY
- pc_write, pc_select, a_select, b_select output 1 each: PC strobe, PC source (1 = ALU), operand A (1 = PC), operand B (1 = imm)
- immediate_select output 3; alu_select output ALU_SEL_W; write_back_select output 2
- register_write_enable, memory_write_enable output 1 each
- illegal, mem_fault output 1 each: one-cycle pulses in WRITEBACK
- busy output 1: state ≠ FETCH
- instret output CNT_W: retired-instruction count

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- FETCH: instr_ready=1. On instr_valid&instr_ready, latch instruction, go to DECODE.
- DECODE: register the control bundle from the latched word. Legal → EXECUTE. Illegal → WRITEBACK with all writes suppressed.
- EXECUTE: for branches, pc_select ← branch_taken. Load/store → MEMORY, else → WRITEBACK.
- MEMORY: mem_req=1 each cycle. memory_write_enable=1 each cycle for stores. A wait counter increments per cycle.
  - mem_ack → WRITEBACK.
  - Counter reaching MEM_WAIT_MAX without ack → WRITEBACK with mem_fault; register write suppressed.
- WRITEBACK, one cycle:
  - pc_write=1.
  - register_write_enable=1 if the instruction writes rd and there is no fault or illegal.
  - instret+1 under the same condition; wraps at 2^CNT_W.
  - Next state FETCH.
- Select lines hold from DECODE through WRITEBACK. In FETCH they hold the last values; in FETCH the strobes are 0.
- immediate_select: 000 none, 001 I, 010 S, 011 B, 100 U, 101 J.
- write_back_select: 00 memory, 01 ALU, 10 PC+4.
- alu_select: add 0, sll 1, slt 2, sltu 3, xor 4, srl 5, or 6, and 7, sub 12, sra 13, passB 15.
- Decode rules:
  - R-type: funct7 must be 0000000, or 0100000 with funct3 000 (sub) or 101 (sra); anything else is illegal.
  - I-ALU: slli/srli need funct7=0000000; srai needs 0100000; else illegal.
  - lui → b=1, imm 100, alu 15. auipc → a=1, b=1, imm 100, alu 0.
  - jal → a=1, b=1, imm 101, pc_select 1, wb 10. jalr → b=1, imm 001, pc_select 1, wb 10.
  - B-type (1100011, funct3 ∉ {010, 011}) → a=1, b=1, imm 011, alu 0, no rd write.
  - Load (funct3 ∈ {000, 001, 010, 100, 101}) → b=1, imm 001, alu 0, wb 00.
  - Store (funct3 ≤ 010) → b=1, imm 010, alu 0 (address add), memory_write_enable in MEMORY.
  - Any other opcode is illegal.
- Non-branch, non-jump instructions: pc_select=0.

## Timing
- Reset: state FETCH; every output 0 except instr_ready, which is 1 from the first cycle after rst deasserts; instret=0; wait counter 0.
- Latency from the accept edge:
  - Non-memory instruction: WRITEBACK is the 3rd cycle; next accept possible on the 4th.
  - Memory instruction: WRITEBACK is the (4+k)th cycle, where mem_ack arrives in the (k+1)th MEMORY cycle.
- mem_ack outside MEMORY is ignored. instr_valid outside FETCH is ignored.
- mem_ack on the same cycle the counter hits MEM_WAIT_MAX: ack wins, no fault.
- rst mid-operation: next cycle is FETCH with mem_req=0 and no pending write. instret keeps nothing; it is reset to 0.

## Structure
- Package control_pkg: opcode constants, alu_select codes, immediate and write-back codes, state enum, control-bundle struct.
- Sub-module control_decode: combinational; takes the instruction and produces the control bundle plus illegal, is_mem, is_branch and writes_rd. It is instantiated once; control_sequencer holds the FSM, registers and counters.

## Test plan
- add 0x002081B3 after reset → accepted; WRITEBACK 3rd cycle: alu_select 0, wb 01, register_write_enable 1, pc_write 1; instret 0→1.
- sub 0x402081B3 → alu_select 12. srai 0x4040D093 → alu_select 13, b_select 1, imm 001.
- sw 0x0020A223, mem_ack in 3rd MEMORY cycle → mem_req and memory_write_enable high exactly 3 cycles, imm 010, alu 0, no register write.
- beq 0x00208463 with branch_taken=1 → pc_select 1, imm 011, pc_write in WRITEBACK. With branch_taken=0 → pc_select 0.
- lw 0x0000A183, MEM_WAIT_MAX=4, no ack → 4 MEMORY cycles, mem_fault pulse, no register write, instret unchanged.
- 0x00000000 → illegal pulse, no writes. Separately, rst during MEMORY → mem_req 0 and instr_ready 1 on the following cycle.
